waterfall_scroller: RTL and testbench
=====================================

// Module: waterfall_scroller
// PURPOSE
//   Parametrised successor to the waterfall scroll controller. Accepts spectrum bins from the
//   sliding DFT into an internal line buffer with per-bin accumulation (replace/peak-hold/IIR
//   average), writes one row into the frame buffer every SCROLL_DIV vertical blanks, and
//   produces wrap-corrected frame-buffer read addresses for the video driver.
//   Scroll direction is selectable. Sits between sdft, ram (frame buffer) and video.
// PARAMETERS
//   H_VISIBLE   320  pixels per row; frame-buffer row stride
//   V_VISIBLE   240  rows; y_offset wraps modulo V_VISIBLE
//   FREQ_BINS   320  bins per line; pixels >= FREQ_BINS are written as 0
//   ADDR_W      9    bin/x address width
//   DATA_W      8    bin and pixel width
//   FB_ADDR_W   17   frame-buffer address width
//   SCROLL_DIV  4    vertical blanks per scroll step (>=1)
// PORTS
//   clk          in   1          pixel clock
//   reset        in   1          synchronous, active-high
//   mode         in   2          0 replace, 1 peak-hold, 2 IIR average, 3 = replace
//   avg_shift    in   3          IIR coefficient k: acc += (in - acc) >>> k
//   scroll_dir   in   1          0 newest row at bottom, 1 newest row at top
//   freeze       in   1          1 = no row writes, no scrolling
//   bin_valid    in   1          bin_addr/bin_data valid
//   bin_ready    out  1          block accepts a bin this cycle
//   bin_addr     in   ADDR_W     bin index
//   bin_data     in   DATA_W     bin magnitude (unsigned)
//   x            in   ADDR_W     video column
//   y            in   8          video row
//   lower_blank  in   1          video in vertical blanking
//   fb_addr      out  FB_ADDR_W  frame-buffer address
//   fb_wdata     out  DATA_W     frame-buffer write data
//   fb_we        out  1          frame-buffer write enable
//   y_offset     out  8          current top row index, 0..V_VISIBLE-1
//   line_done    out  1          one-cycle pulse after a row write completes
// BEHAVIOUR
// - Reset: fb_addr=0, fb_wdata=0, fb_we=0, bin_ready=0, y_offset=0, line_done=0, scroll
//   counter=0, state=CLEAR. Reset in any state, incl. mid-CLEAR/mid-WRITE, restarts CLEAR at 0.
// - CLEAR: fb_we=1, fb_wdata=0, fb_addr 0..H*V-1 one per cycle; line buffer zeroed in parallel;
//   then fb_we=0 -> VIDEO. Takes exactly H_VISIBLE*V_VISIBLE cycles.
// - VIDEO: row = (y+y_offset) >= V ? y+y_offset-V : y+y_offset (registered);
//   fb_addr = x + row*H_VISIBLE (registered). Read-address latency 2 cycles from x/y.
//   On lower_blank: counter++; if counter==SCROLL_DIV-1 and !freeze -> WRITE (counter=0),
//   else -> WAIT_VIDEO.
// - WRITE: H_VISIBLE+2 cycles; pixel i (0..H-1) written to row w*H + i, data = line_buf[i] for
//   i<FREQ_BINS else 0; fb_we high exactly H_VISIBLE cycles. dir 0: w=y_offset, then
//   y_offset++ (V-1 wraps to 0). dir 1: y_offset-- first (0 wraps to V-1), w=new y_offset.
//   Mode 1: each entry zeroed after readout. line_done pulses the cycle after last write;
//   -> WAIT_VIDEO. Caller guarantees blanking >= H_VISIBLE+4 cycles.
// - WAIT_VIDEO: -> VIDEO when lower_blank deasserts.
// - Bin intake (VIDEO/WAIT_VIDEO only; bin_ready=0 in CLEAR and WRITE): handshake on
//   bin_valid&bin_ready. Read-modify-write, 2 cycles: bin_ready drops the cycle after a
//   transfer, returns next cycle (max 1 bin / 2 cycles). bin_addr >= FREQ_BINS: accepted, dropped.
//   mode 0: buf=in. mode 1: buf=max(buf,in). mode 2: signed DATA_W+1 diff, arithmetic shift,
//   result clamped to 0..2^DATA_W-1.
// - Mode/avg_shift/scroll_dir sampled at each transfer/WRITE start; changes never corrupt a row.
// TESTING
// 1. Reset, H=8,V=4 -> fb_we high 32 cycles, addr 0..31 data 0; bin_ready=0 until VIDEO.
// 2. mode0 bins 0..7 = 10..17, SCROLL_DIV=1, one blank -> writes row 0 values 10..17, y_offset=1, line_done 1 pulse.
// 3. y_offset=3 (V=4), y=2, x=5 -> fb_addr=1*8+5=13 two cycles later; dir0 write at y_offset=3 -> y_offset=0.
// 4. mode1 bin0: 50,200,30 -> row pixel 0 = 200; next row with no bins -> 0.
// 5. mode2 k=1, buf=100, in 20 -> buf=60; in 255 from 250 k=0 -> 255 (no overflow).
// 6. Assert reset mid-WRITE -> fb_we drops next cycle, CLEAR restarts at addr 0; freeze=1 -> no WRITE.

Source files
------------

// File: rtl/waterfall_scroller.sv
// Waterfall scroll controller: accumulates spectrum bins into a line buffer, scrolls one row
// into the frame buffer every SCROLL_DIV vertical blanks and wraps video read addresses.
module waterfall_scroller #(
  parameter int H_VISIBLE  = 320,
  parameter int V_VISIBLE  = 240,
  parameter int FREQ_BINS  = 320,
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 8,
  parameter int FB_ADDR_W  = 17,
  parameter int SCROLL_DIV = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           mode,
  input  logic [2:0]           avg_shift,
  input  logic                 scroll_dir,
  input  logic                 freeze,
  input  logic                 bin_valid,
  output logic                 bin_ready,
  input  logic [ADDR_W-1:0]    bin_addr,
  input  logic [DATA_W-1:0]    bin_data,
  input  logic [ADDR_W-1:0]    x,
  input  logic [7:0]           y,
  input  logic                 lower_blank,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [DATA_W-1:0]    fb_wdata,
  output logic                 fb_we,
  output logic [7:0]           y_offset,
  output logic                 line_done
);
  localparam logic [1:0] S_CLEAR = 2'd0, S_VIDEO = 2'd1, S_WRITE = 2'd2, S_WAIT = 2'd3;
  localparam int SC_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int WC_W = $clog2(H_VISIBLE + 2);
  localparam logic [FB_ADDR_W-1:0] FB_LAST = FB_ADDR_W'(H_VISIBLE * V_VISIBLE - 1);
  localparam logic [FB_ADDR_W-1:0] H_FB    = FB_ADDR_W'(H_VISIBLE);
  localparam logic [ADDR_W:0]      BIN_LIM = (ADDR_W + 1)'(FREQ_BINS);
  localparam logic [7:0]           V_LAST  = 8'(V_VISIBLE - 1);
  localparam logic [8:0]           V_9     = 9'(V_VISIBLE);
  localparam logic [SC_W-1:0]      SC_LAST = SC_W'(SCROLL_DIV - 1);
  localparam logic [WC_W-1:0]      WC_LAST = WC_W'(H_VISIBLE + 1);
  localparam logic [DATA_W-1:0]    D_MAX   = '1;

  logic [1:0]           state, state_nxt;
  logic [FB_ADDR_W-1:0] clr_cnt, wbase;
  logic [SC_W-1:0]      scroll_cnt;
  logic [WC_W-1:0]      wcnt;
  logic [ADDR_W-1:0]    x_d, rd_idx;
  logic [7:0]           row_r, y_inc, y_dec, wrow;
  logic [8:0]           ysum;
  logic                 wmode_pk, xfer, rd_in, rmw_in;
  logic [DATA_W-1:0]    line_buf [FREQ_BINS];

  logic                 rmw_vld;
  logic [ADDR_W-1:0]    rmw_addr;
  logic [DATA_W-1:0]    rmw_data, rmw_cur, rmw_upd;
  logic [1:0]           rmw_mode;
  logic [2:0]           rmw_k;
  logic signed [DATA_W:0]   diff, step_v;
  logic signed [DATA_W+1:0] acc_n;

  assign xfer   = bin_valid & bin_ready;
  assign ysum   = {1'b0, y} + {1'b0, y_offset};
  assign y_inc  = (y_offset == V_LAST) ? 8'd0 : y_offset + 8'd1;
  assign y_dec  = (y_offset == 8'd0) ? V_LAST : y_offset - 8'd1;
  // Upward scroll moves the top pointer first, so the new row lands at the new top.
  assign wrow   = scroll_dir ? y_dec : y_offset;
  assign rd_idx = ADDR_W'(wcnt - WC_W'(1));
  assign rd_in  = {1'b0, rd_idx} < BIN_LIM;
  assign rmw_in = {1'b0, rmw_addr} < BIN_LIM;
  assign rmw_cur = rmw_in ? line_buf[rmw_addr] : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR: if (clr_cnt == FB_LAST) state_nxt = S_VIDEO;
      S_VIDEO: if (lower_blank) state_nxt = (scroll_cnt == SC_LAST && !freeze) ? S_WRITE : S_WAIT;
      S_WRITE: if (wcnt == WC_LAST) state_nxt = S_WAIT;
      default: if (!lower_blank) state_nxt = S_VIDEO;
    endcase
  end

  // Second half of the read-modify-write; the IIR step is done in DATA_W+2 bits then clamped.
  always_comb begin
    diff   = $signed({1'b0, rmw_data}) - $signed({1'b0, rmw_cur});
    step_v = diff >>> rmw_k;
    acc_n  = $signed({2'b00, rmw_cur}) + $signed({step_v[DATA_W], step_v});
    rmw_upd = rmw_data;
    case (rmw_mode)
      2'd1: if (rmw_cur > rmw_data) rmw_upd = rmw_cur;
      2'd2: begin
        if (acc_n[DATA_W+1])  rmw_upd = '0;
        else if (acc_n[DATA_W]) rmw_upd = D_MAX;
        else                  rmw_upd = acc_n[DATA_W-1:0];
      end
      default: rmw_upd = rmw_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_CLEAR;
      clr_cnt    <= '0;
      scroll_cnt <= '0;
      wcnt       <= '0;
      wbase      <= '0;
      wmode_pk   <= 1'b0;
      y_offset   <= 8'd0;
      x_d        <= '0;
      row_r      <= 8'd0;
      fb_addr    <= '0;
      fb_wdata   <= '0;
      fb_we      <= 1'b0;
      bin_ready  <= 1'b0;
      line_done  <= 1'b0;
      rmw_vld    <= 1'b0;
      rmw_addr   <= '0;
      rmw_data   <= '0;
      rmw_mode   <= 2'd0;
      rmw_k      <= 3'd0;
    end else begin
      state     <= state_nxt;
      bin_ready <= (state_nxt == S_VIDEO || state_nxt == S_WAIT) && !xfer;
      line_done <= 1'b0;
      rmw_vld   <= xfer;
      if (xfer) begin
        rmw_addr <= bin_addr;
        rmw_data <= bin_data;
        rmw_mode <= mode;
        rmw_k    <= avg_shift;
      end
      if (rmw_vld && rmw_in) line_buf[rmw_addr] <= rmw_upd;
      case (state)
        S_CLEAR: begin
          fb_we    <= 1'b1;
          fb_wdata <= '0;
          fb_addr  <= clr_cnt;
          clr_cnt  <= clr_cnt + FB_ADDR_W'(1);
          for (int i = 0; i < FREQ_BINS; i++) line_buf[i] <= '0;
        end
        S_WRITE: begin
          wcnt <= wcnt + WC_W'(1);
          if (wcnt == '0) begin
            fb_we    <= 1'b0;
            wmode_pk <= (mode == 2'd1);
            wbase    <= FB_ADDR_W'(wrow) * H_FB;
            y_offset <= scroll_dir ? y_dec : y_inc;
          end else if (wcnt != WC_LAST) begin
            fb_we    <= 1'b1;
            fb_addr  <= wbase + FB_ADDR_W'(rd_idx);
            fb_wdata <= rd_in ? line_buf[rd_idx] : '0;
            if (wmode_pk && rd_in) line_buf[rd_idx] <= '0;
          end else begin
            fb_we     <= 1'b0;
            line_done <= 1'b1;
          end
        end
        default: begin
          fb_we   <= 1'b0;
          wcnt    <= '0;
          x_d     <= x;
          row_r   <= (ysum >= V_9) ? 8'(ysum - V_9) : ysum[7:0];
          fb_addr <= FB_ADDR_W'(x_d) + FB_ADDR_W'(row_r) * H_FB;
          if (state == S_VIDEO && lower_blank)
            scroll_cnt <= (scroll_cnt == SC_LAST) ? '0 : scroll_cnt + SC_W'(1);
        end
      endcase
    end
  end
endmodule

// File: tb/tb_waterfall_scroller.sv
// Directed + randomized bench for waterfall_scroller with a line-buffer / frame model.
module tb_waterfall_scroller;
  localparam int H = 8, V = 4, FB = 6, AW = 4, DW = 8, FAW = 5, DIV = 2;

  logic clk = 1'b0, reset = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [2:0] avg_shift = 3'd0;
  logic scroll_dir = 1'b0, freeze = 1'b0, bin_valid = 1'b0, lower_blank = 1'b0;
  logic [AW-1:0] bin_addr = '0, x = '0;
  logic [DW-1:0] bin_data = '0;
  logic [7:0] y = 8'd0;
  logic bin_ready, fb_we, line_done;
  logic [FAW-1:0] fb_addr;
  logic [DW-1:0] fb_wdata;
  logic [7:0] y_offset;

  waterfall_scroller #(.H_VISIBLE(H), .V_VISIBLE(V), .FREQ_BINS(FB), .ADDR_W(AW),
    .DATA_W(DW), .FB_ADDR_W(FAW), .SCROLL_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .mode(mode), .avg_shift(avg_shift), .scroll_dir(scroll_dir),
    .freeze(freeze), .bin_valid(bin_valid), .bin_ready(bin_ready), .bin_addr(bin_addr),
    .bin_data(bin_data), .x(x), .y(y), .lower_blank(lower_blank), .fb_addr(fb_addr),
    .fb_wdata(fb_wdata), .fb_we(fb_we), .y_offset(y_offset), .line_done(line_done));

  always #5 clk = ~clk;

  int compared = 0, mismatched = 0;
  int mbuf [FB];
  int fbm [H*V];
  int y_off = 0, scnt = 0, we_cnt = 0, ld_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; observes the frame-buffer port as a memory would.
  task automatic step();
    @(negedge clk);
    if (fb_we === 1'b1) begin fbm[fb_addr] = fb_wdata; we_cnt++; end
    if (line_done === 1'b1) ld_cnt++;
  endtask

  task automatic mdl_reset();
    y_off = 0; scnt = 0;
    for (int i = 0; i < FB; i++) mbuf[i] = 0;
  endtask

  task automatic mdl_bin(input int a, input int d);
    int df, q, s, r;
    if (a >= FB) return;
    case (mode)
      2'd1: if (d > mbuf[a]) mbuf[a] = d;
      2'd2: begin
        df = d - mbuf[a]; q = 1 << avg_shift;
        s = (df >= 0) ? df / q : -((-df + q - 1) / q);
        r = mbuf[a] + s;
        mbuf[a] = (r < 0) ? 0 : (r > 255) ? 255 : r;
      end
      default: mbuf[a] = d;
    endcase
  endtask

  task automatic send_bin(input int a, input int d);
    int t = 0;
    while (bin_ready !== 1'b1 && t < 20) begin step(); t++; end
    if (bin_ready !== 1'b1) begin chk("bin_ready_timeout", bin_ready, 1); return; end
    bin_valid = 1'b1; bin_addr = AW'(a); bin_data = DW'(d);
    mdl_bin(a, d);
    step();
    bin_valid = 1'b0;
  endtask

  task automatic clear_check();
    int n = 0;
    bit addr_ok = 1, data_ok = 1, rdy_ok = 1;
    for (int c = 0; c < H*V + 8; c++) begin
      step();
      if (fb_we === 1'b1) begin
        if (fb_addr !== FAW'(n)) addr_ok = 0;
        if (fb_wdata !== 8'd0) data_ok = 0;
        if (bin_ready !== 1'b0 && n < H*V - 1) rdy_ok = 0;
        n++;
      end
    end
    chk("clear_we_cycles", n, H*V);
    chk("clear_addr_seq", addr_ok, 1);
    chk("clear_data_zero", data_ok, 1);
    chk("clear_ready_low", rdy_ok, 1);
    chk("ready_after_clear", bin_ready, 1);
    chk("yoff_after_clear", y_offset, 0);
  endtask

  task automatic blank(input bit frz, output int w);
    int we0, ld0, exp_row [H];
    bit wr = 0;
    we0 = we_cnt; ld0 = ld_cnt; w = 0;
    for (int i = 0; i < H; i++) exp_row[i] = 0;
    scnt++;
    if (scnt == DIV) begin scnt = 0; wr = !frz; end
    if (wr) begin
      if (scroll_dir) begin y_off = (y_off + V - 1) % V; w = y_off; end
      else begin w = y_off; y_off = (y_off + 1) % V; end
      for (int i = 0; i < FB; i++) exp_row[i] = mbuf[i];
      if (mode == 2'd1) for (int i = 0; i < FB; i++) mbuf[i] = 0;
    end
    freeze = frz; lower_blank = 1'b1;
    repeat (H + 8) step();
    lower_blank = 1'b0;
    repeat (3) step();
    freeze = 1'b0;
    chk("row_we_cycles", we_cnt - we0, wr ? H : 0);
    chk("line_done_pulses", ld_cnt - ld0, wr ? 1 : 0);
    chk("y_offset", y_offset, y_off);
    if (wr) for (int i = 0; i < H; i++) chk("row_pixel", fbm[w*H + i], exp_row[i]);
  endtask

  task automatic row_write(output int w);
    if (scnt != DIV - 1) blank(1'b0, w);
    blank(1'b0, w);
  endtask

  task automatic vid_check(input int xv, input int yv);
    x = AW'(xv); y = 8'(yv);
    step(); step();
    chk("video_addr", fb_addr, xv + ((yv + y_off) % V) * H);
  endtask

  initial begin
    int w, t, nz;
    mdl_reset();
    repeat (3) step();
    chk("rst_fb_we", fb_we, 0);
    chk("rst_fb_addr", fb_addr, 0);
    chk("rst_fb_wdata", fb_wdata, 0);
    chk("rst_bin_ready", bin_ready, 0);
    chk("rst_y_offset", y_offset, 0);
    chk("rst_line_done", line_done, 0);
    reset = 1'b0;
    clear_check();

    repeat (4) vid_check($urandom_range(0, H-1), $urandom_range(0, V-1));

    // Replace mode, bins 0..7 = 10..17; bins past FREQ_BINS are dropped.
    mode = 2'd0;
    for (int i = 0; i < 8; i++) send_bin(i, 10 + i);
    chk("hs_ready_drop", bin_ready, 0);
    step();
    chk("hs_ready_back", bin_ready, 1);
    row_write(w);
    chk("t2_px0", fbm[w*H], 10);
    chk("t2_px5", fbm[w*H + 5], 15);
    chk("t2_px7", fbm[w*H + 7], 0);
    chk("t2_yoff", y_offset, 1);

    // Peak hold, then zeroed by readout.
    mode = 2'd1;
    send_bin(0, 50); send_bin(0, 200); send_bin(0, 30);
    row_write(w);
    chk("peak_px0", fbm[w*H], 200);
    row_write(w);
    chk("peak_cleared_px0", fbm[w*H], 0);

    // IIR average and its saturation edge.
    mode = 2'd0; send_bin(0, 100); send_bin(1, 250);
    mode = 2'd2; avg_shift = 3'd1; send_bin(0, 20);
    avg_shift = 3'd0; send_bin(1, 255);
    row_write(w);
    chk("iir_px0", fbm[w*H], 60);
    chk("iir_px1", fbm[w*H + 1], 255);

    // Randomized rounds: modes, shifts, directions, freeze, out-of-range bins.
    for (int r = 0; r < 8; r++) begin
      mode = 2'($urandom_range(0, 3));
      avg_shift = 3'($urandom_range(0, 7));
      scroll_dir = 1'($urandom_range(0, 1));
      for (int b = 0; b < 8; b++) send_bin($urandom_range(0, 9), $urandom_range(0, 255));
      mode = 2'($urandom_range(0, 3));
      if (r % 3 == 1) blank(1'b1, w);
      row_write(w);
      vid_check($urandom_range(0, H-1), $urandom_range(0, V-1));
    end

    // Top row 3, video row 2 wraps to frame row 1; then bottom-scroll wrap 3 -> 0.
    scroll_dir = 1'b0;
    for (int i = 0; i < V && y_off != 3; i++) row_write(w);
    vid_check(5, 2);
    chk("t3_addr", fb_addr, 13);
    row_write(w);
    chk("t3_wrap", y_offset, 0);

    // Reset in the middle of a row write.
    if (scnt != DIV - 1) blank(1'b0, w);
    lower_blank = 1'b1;
    t = 0;
    while (fb_we !== 1'b1 && t < 20) begin step(); t++; end
    chk("midwrite_we_seen", fb_we, 1);
    repeat (3) step();
    reset = 1'b1;
    step();
    chk("midwrite_we_drop", fb_we, 0);
    chk("midwrite_ready_low", bin_ready, 0);
    step();
    reset = 1'b0; lower_blank = 1'b0;
    mdl_reset();
    clear_check();
    nz = 0;
    for (int i = 0; i < H*V; i++) if (fbm[i] != 0) nz++;
    chk("frame_cleared", nz, 0);

    // Top-scroll wrap 0 -> V-1 with the buffer empty after reset.
    scroll_dir = 1'b1; mode = 2'd0;
    row_write(w);
    chk("dir1_wrap", y_offset, V - 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
